// File: rtl/aes_ahb_pkg.sv
// Shared AHB-Lite encodings, register map and slave FSM states for the AES core bus interface.
package aes_ahb_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned KEY_W     = 128;
    localparam int unsigned OFF_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } ahb_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [OFF_W-1:0] OFF_CTRL   = 8'h00;
    localparam logic [OFF_W-1:0] OFF_STATUS = 8'h04;
    localparam logic [OFF_W-1:0] OFF_SRC    = 8'h08;
    localparam logic [OFF_W-1:0] OFF_DST    = 8'h0C;
    localparam logic [OFF_W-1:0] OFF_SIZE   = 8'h10;
    localparam logic [OFF_W-1:0] OFF_KEY0   = 8'h14;
    localparam logic [OFF_W-1:0] OFF_KEY1   = 8'h18;
    localparam logic [OFF_W-1:0] OFF_KEY2   = 8'h1C;
    localparam logic [OFF_W-1:0] OFF_KEY3   = 8'h20;

endpackage

// File: rtl/ahb_slave.sv
// AHB-Lite register slave for the AES core: control/status, DMA pointers and key,
// zero-wait OKAY for legal word accesses and a two-cycle ERROR response otherwise.
module ahb_slave
    import aes_ahb_pkg::*;
(
    input  logic              hclk,
    input  logic              n_rst,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic              start,
    output logic              mode,
    output logic [ADDR_W-1:0] src_addr,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [DATA_W-1:0] size,
    output logic [KEY_W-1:0]  key,
    input  logic              busy,
    input  logic              done
);

    ahb_state_t       state, next_state;
    logic [OFF_W-1:0] addr_q;
    logic             write_q;
    logic             done_flag;
    logic             accept;
    logic             legal;
    logic             ctrl_err;
    logic             do_write;

    // Word-sized, word-aligned access to a mapped offset in the low 256 bytes.
    function automatic logic legal_access(input logic [ADDR_W-1:0] a, input logic [2:0] sz);
        logic mapped;
        case (a[OFF_W-1:0])
            OFF_CTRL, OFF_STATUS, OFF_SRC, OFF_DST, OFF_SIZE,
            OFF_KEY0, OFF_KEY1, OFF_KEY2, OFF_KEY3: mapped = 1'b1;
            default:                                mapped = 1'b0;
        endcase
        return mapped && (a[ADDR_W-1:OFF_W] == '0) && (a[1:0] == 2'b00) && (sz == HSIZE_WORD);
    endfunction

    // START needs write data, so a start-while-busy request is only detectable in the data
    // phase; that cycle itself becomes the first ERROR cycle and the FSM moves to ERR2.
    assign ctrl_err = (state == ST_DATA) && write_q && (addr_q == OFF_CTRL) && hwdata[0] && busy;
    assign do_write = (state == ST_DATA) && write_q && !ctrl_err;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        legal      = legal_access(haddr, hsize);
        hreadyout  = 1'b1;
        hresp      = 1'b0;
        case (state)
            ST_IDLE, ST_ERR2: begin
                hresp  = (state == ST_ERR2);
                accept = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
            end
            ST_DATA: begin
                if (ctrl_err) begin
                    hreadyout = 1'b0;
                    hresp     = 1'b1;
                end else begin
                    accept = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            default: ;
        endcase
        if (state == ST_ERR1 || ctrl_err) begin
            next_state = ST_ERR2;
        end else if (accept) begin
            next_state = legal ? ST_DATA : ST_ERR1;
        end else begin
            next_state = ST_IDLE;
        end
    end

    always_ff @(posedge hclk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                addr_q  <= haddr[OFF_W-1:0];
                write_q <= hwrite;
            end
        end
    end

    // Register file; done wins over a same-cycle write-1-to-clear of DONE.
    always_ff @(posedge hclk or negedge n_rst) begin
        if (!n_rst) begin
            start     <= 1'b0;
            mode      <= 1'b0;
            src_addr  <= '0;
            dst_addr  <= '0;
            size      <= '0;
            key       <= '0;
            done_flag <= 1'b0;
        end else begin
            start <= do_write && (addr_q == OFF_CTRL) && hwdata[0];
            if (do_write) begin
                case (addr_q)
                    OFF_CTRL: mode           <= hwdata[1];
                    OFF_SRC:  src_addr       <= hwdata;
                    OFF_DST:  dst_addr       <= hwdata;
                    OFF_SIZE: size           <= hwdata;
                    OFF_KEY0: key[31:0]      <= hwdata;
                    OFF_KEY1: key[63:32]     <= hwdata;
                    OFF_KEY2: key[95:64]     <= hwdata;
                    OFF_KEY3: key[127:96]    <= hwdata;
                    default: ;
                endcase
            end
            if (done) begin
                done_flag <= 1'b1;
            end else if (do_write && (addr_q == OFF_STATUS) && hwdata[1]) begin
                done_flag <= 1'b0;
            end
        end
    end

    // Read data straight from the registers so a read right after a write sees the new value.
    always_comb begin
        hrdata = '0;
        if (state == ST_DATA && !write_q) begin
            case (addr_q)
                OFF_CTRL:   hrdata = {30'b0, mode, 1'b0};
                OFF_STATUS: hrdata = {30'b0, done_flag, busy};
                OFF_SRC:    hrdata = src_addr;
                OFF_DST:    hrdata = dst_addr;
                OFF_SIZE:   hrdata = size;
                default:    hrdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave.sv
// Directed bench for ahb_slave: register access, key load, error responses,
// start/busy interaction, sticky DONE and reset during a transfer.
module tb_ahb_slave;

    logic         hclk = 1'b0;
    logic         n_rst = 1'b0;
    logic         hsel = 1'b0;
    logic [31:0]  haddr = '0;
    logic [1:0]   htrans = 2'b00;
    logic         hwrite = 1'b0;
    logic [2:0]   hsize = 3'b010;
    logic [31:0]  hwdata = '0;
    logic         hready;
    logic         hreadyout;
    logic         hresp;
    logic [31:0]  hrdata;
    logic         start;
    logic         mode;
    logic [31:0]  src_addr;
    logic [31:0]  dst_addr;
    logic [31:0]  size;
    logic [127:0] key;
    logic         busy = 1'b0;
    logic         done = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    assign hready = hreadyout;

    always #5 hclk = ~hclk;

    ahb_slave dut (
        .hclk(hclk), .n_rst(n_rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .start(start),
        .mode(mode), .src_addr(src_addr), .dst_addr(dst_addr), .size(size),
        .key(key), .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive_addr(input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel   = 1'b1;
        haddr  = a;
        htrans = 2'b10;
        hwrite = w;
        hsize  = sz;
    endtask

    task automatic drive_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'b010;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        drive_idle();
        repeat (3) @(posedge hclk);
        #1;
        vectors++; if (hreadyout !== 1'b1) begin miscompares++; $display("FAIL rst_hreadyout: got %b want 1", hreadyout); end
        vectors++; if (hresp !== 1'b0) begin miscompares++; $display("FAIL rst_hresp: got %b want 0", hresp); end
        vectors++; if (hrdata !== 32'h0) begin miscompares++; $display("FAIL rst_hrdata: got %h want 0", hrdata); end
        vectors++; if (start !== 1'b0 || mode !== 1'b0) begin miscompares++; $display("FAIL rst_start_mode: got %b%b want 00", start, mode); end
        vectors++; if (src_addr !== 32'h0 || dst_addr !== 32'h0 || size !== 32'h0) begin miscompares++; $display("FAIL rst_regs: got %h %h %h want 0", src_addr, dst_addr, size); end
        vectors++; if (key !== 128'h0) begin miscompares++; $display("FAIL rst_key: got %h want 0", key); end
        n_rst = 1'b1;
        tick();
        drive_addr(32'h04, 1'b0, 3'b010);
        tick();
        drive_idle();
        vectors++; if (hrdata !== 32'h0) begin miscompares++; $display("FAIL rst_status: got %h want 0", hrdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive_addr(32'h08, 1'b1, 3'b010);
        tick();
        hwdata = 32'h0000_1000;
        drive_addr(32'h08, 1'b0, 3'b010);
        vectors++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin miscompares++; $display("FAIL b2b_wr_resp: got %b/%b want 1/0", hreadyout, hresp); end
        tick();
        drive_idle();
        vectors++; if (hrdata !== 32'h0000_1000) begin miscompares++; $display("FAIL b2b_rd_data: got %h want 00001000", hrdata); end
        vectors++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin miscompares++; $display("FAIL b2b_rd_resp: got %b/%b want 1/0", hreadyout, hresp); end
        tick();
        vectors++; if (hrdata !== 32'h0) begin miscompares++; $display("FAIL b2b_idle_data: got %h want 0", hrdata); end
        // IDLE transfer to an unmapped offset must not error
        hsel = 1'b1; haddr = 32'h40; htrans = 2'b00; hwrite = 1'b0;
        tick();
        drive_idle();
        vectors++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin miscompares++; $display("FAIL idle_xfer: got %b/%b want 1/0", hreadyout, hresp); end
        tick();
    endtask

    task automatic test_key();
        logic [31:0] vals [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
        drive_addr(32'h14, 1'b1, 3'b010);
        for (int i = 0; i < 4; i++) begin
            tick();
            hwdata = vals[i];
            if (i < 3) drive_addr(32'h18 + 32'(4 * i), 1'b1, 3'b010);
            else       drive_addr(32'h14, 1'b0, 3'b010);
        end
        tick();
        drive_idle();
        vectors++; if (key !== 128'h0000000D_0000000C_0000000B_0000000A) begin miscompares++; $display("FAIL key_value: got %h want 0000000d0000000c0000000b0000000a", key); end
        vectors++; if (hrdata !== 32'h0) begin miscompares++; $display("FAIL key_readback: got %h want 0", hrdata); end
        tick();
    endtask

    task automatic test_error();
        drive_addr(32'h40, 1'b0, 3'b010);
        tick();
        drive_idle();
        vectors++; if (hreadyout !== 1'b0 || hresp !== 1'b1) begin miscompares++; $display("FAIL err_unmapped_e1: got %b/%b want 0/1", hreadyout, hresp); end
        tick();
        vectors++; if (hreadyout !== 1'b1 || hresp !== 1'b1) begin miscompares++; $display("FAIL err_unmapped_e2: got %b/%b want 1/1", hreadyout, hresp); end
        tick();
        vectors++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin miscompares++; $display("FAIL err_recover: got %b/%b want 1/0", hreadyout, hresp); end
        drive_addr(32'h08, 1'b1, 3'b000);
        tick();
        hwdata = 32'hDEAD_BEEF;
        drive_idle();
        vectors++; if (hreadyout !== 1'b0 || hresp !== 1'b1) begin miscompares++; $display("FAIL err_hsize_e1: got %b/%b want 0/1", hreadyout, hresp); end
        tick();
        vectors++; if (hreadyout !== 1'b1 || hresp !== 1'b1) begin miscompares++; $display("FAIL err_hsize_e2: got %b/%b want 1/1", hreadyout, hresp); end
        tick();
        vectors++; if (src_addr !== 32'h0000_1000) begin miscompares++; $display("FAIL err_no_write: got %h want 00001000", src_addr); end
        drive_addr(32'h0100_000C, 1'b1, 3'b010);
        tick();
        hwdata = 32'h1234_5678;
        drive_idle();
        vectors++; if (hresp !== 1'b1) begin miscompares++; $display("FAIL err_highaddr: got %b want 1", hresp); end
        tick();
        tick();
        vectors++; if (dst_addr !== 32'h0) begin miscompares++; $display("FAIL err_highaddr_reg: got %h want 0", dst_addr); end
    endtask

    task automatic test_ctrl();
        busy = 1'b0;
        drive_addr(32'h00, 1'b1, 3'b010);
        tick();
        hwdata = 32'h3;
        drive_addr(32'h00, 1'b0, 3'b010);
        vectors++; if (start !== 1'b0 || hresp !== 1'b0) begin miscompares++; $display("FAIL ctrl_dphase: got start=%b hresp=%b want 0/0", start, hresp); end
        tick();
        drive_idle();
        vectors++; if (start !== 1'b1 || mode !== 1'b1) begin miscompares++; $display("FAIL ctrl_start: got start=%b mode=%b want 1/1", start, mode); end
        vectors++; if (hrdata !== 32'h2) begin miscompares++; $display("FAIL ctrl_read: got %h want 2", hrdata); end
        tick();
        vectors++; if (start !== 1'b0) begin miscompares++; $display("FAIL ctrl_pulse_len: got %b want 0", start); end
        busy = 1'b1;
        drive_addr(32'h00, 1'b1, 3'b010);
        tick();
        hwdata = 32'h1;
        drive_idle();
        vectors++; if (hreadyout !== 1'b0 || hresp !== 1'b1) begin miscompares++; $display("FAIL busy_e1: got %b/%b want 0/1", hreadyout, hresp); end
        tick();
        vectors++; if (hreadyout !== 1'b1 || hresp !== 1'b1 || start !== 1'b0) begin miscompares++; $display("FAIL busy_e2: got %b/%b start=%b want 1/1 0", hreadyout, hresp, start); end
        tick();
        vectors++; if (start !== 1'b0 || mode !== 1'b1) begin miscompares++; $display("FAIL busy_nostart: got start=%b mode=%b want 0/1", start, mode); end
        busy = 1'b0;
    endtask

    task automatic test_done();
        drive_addr(32'h04, 1'b1, 3'b010);
        tick();
        hwdata = 32'h2;
        done = 1'b1;
        drive_addr(32'h04, 1'b0, 3'b010);
        tick();
        done = 1'b0;
        drive_idle();
        vectors++; if (hrdata !== 32'h2) begin miscompares++; $display("FAIL done_priority: got %h want 2", hrdata); end
        drive_addr(32'h04, 1'b1, 3'b010);
        tick();
        hwdata = 32'h2;
        drive_addr(32'h04, 1'b0, 3'b010);
        tick();
        drive_idle();
        vectors++; if (hrdata !== 32'h0) begin miscompares++; $display("FAIL done_clear: got %h want 0", hrdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive_addr(32'h10, 1'b1, 3'b010);
        tick();
        hwdata = 32'h55;
        drive_idle();
        n_rst = 1'b0;
        #1;
        vectors++; if (hreadyout !== 1'b1 || size !== 32'h0) begin miscompares++; $display("FAIL rstmid_during: got rdy=%b size=%h want 1/0", hreadyout, size); end
        tick();
        n_rst = 1'b1;
        tick();
        vectors++; if (size !== 32'h0 || hreadyout !== 1'b1 || start !== 1'b0) begin miscompares++; $display("FAIL rstmid_after: got size=%h rdy=%b start=%b want 0/1/0", size, hreadyout, start); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_key();
        test_error();
        test_ctrl();
        test_done();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
